// File: rtl/mem_clint_mh_if.sv
// Device-bus request/response bundle for the multi-hart CLINT.
// The slave modport is the CLINT side; the master modport is the memory stage.
interface mem_clint_mh_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic [63:0]       req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [63:0]       resp_rdata_o;
  logic [1:0]        resp_code_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_code_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_code_o
  );
endinterface

// File: rtl/mem_clint_mh.sv
// Multi-hart CLINT: prescaled mtime, per-hart mtimecmp/msip, registered mtip/msip lines.
// Response one cycle after accept; request port stalls until the response is consumed.
module mem_clint_mh #(
  parameter int                HART_NUM  = 2,
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h0200_0000),
  parameter int                TICK_DIV  = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_clint_mh_if.slave       bus,
  output logic [HART_NUM-1:0] mtip_o,
  output logic [HART_NUM-1:0] msip_o,
  output logic                update_o
);
  localparam int         PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_MIS = 2'b10;
  localparam logic [1:0] CODE_DEC = 2'b11;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;
  typedef enum logic [1:0] {RG_MSIP, RG_CMP, RG_MTIME, RG_NONE} region_e;

  state_e              r_state;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_code;
  logic [PW-1:0]       r_presc;
  logic [DATA_W-1:0]   r_mtime;
  logic [DATA_W-1:0]   r_cmp [HART_NUM];
  logic [HART_NUM-1:0] r_msip;
  logic [HART_NUM-1:0] r_mtip;
  logic                r_update;

  logic [ADDR_W-1:0]   w_off;
  region_e             w_region;
  logic [2:0]          w_lane;
  logic [2:0]          w_align;
  logic [7:0]          w_bmask;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_cur;
  logic [DATA_W-1:0]   w_merged;
  logic [1:0]          w_code;
  logic                w_acc;
  logic                w_wr_ok;
  logic                w_tick;
  logic [DATA_W-1:0]   w_mtime_nxt;
  logic [DATA_W-1:0]   w_cmp_nxt [HART_NUM];
  logic [HART_NUM-1:0] w_msip_nxt;

  always_comb begin
    w_off  = bus.req_addr_i - BASE_ADDR;
    w_lane = bus.req_addr_i[2:0];
    case (bus.req_size_i)
      2'd0:    begin w_bmask = 8'h01; w_align = 3'b000; end
      2'd1:    begin w_bmask = 8'h03; w_align = 3'b001; end
      2'd2:    begin w_bmask = 8'h0F; w_align = 3'b011; end
      default: begin w_bmask = 8'hFF; w_align = 3'b111; end
    endcase
    w_bmask = w_bmask << w_lane;
    for (int i = 0; i < 8; i++) begin
      w_mask[8*i +: 8] = {8{w_bmask[i]}};
    end

    if (w_off < ADDR_W'(4 * HART_NUM)) begin
      w_region = RG_MSIP;
    end else if (w_off >= ADDR_W'(32'h4000) && w_off < ADDR_W'(32'h4000 + 8 * HART_NUM)) begin
      w_region = RG_CMP;
    end else if (w_off >= ADDR_W'(32'hBFF8) && w_off < ADDR_W'(32'hC000)) begin
      w_region = RG_MTIME;
    end else begin
      w_region = RG_NONE;
    end

    // MSIP words are 32-bit, so a dword access there cannot be honoured
    if (w_region == RG_NONE) begin
      w_code = CODE_DEC;
    end else if ((w_lane & w_align) != 3'b000 ||
                 (w_region == RG_MSIP && bus.req_size_i == 2'd3)) begin
      w_code = CODE_MIS;
    end else begin
      w_code = CODE_OK;
    end

    // Doubleword view of the target: an MSIP pair packs even hart in lanes 0-3, odd in 4-7
    w_cur = '0;
    case (w_region)
      RG_MSIP: begin
        for (int h = 0; h < HART_NUM; h++) begin
          if (h / 2 == int'(w_off[4:3])) begin
            if (h % 2 == 1) w_cur[32] = r_msip[h];
            else            w_cur[0]  = r_msip[h];
          end
        end
      end
      RG_CMP: begin
        for (int h = 0; h < HART_NUM; h++) begin
          if (h == int'(w_off[5:3])) w_cur = r_cmp[h];
        end
      end
      RG_MTIME: w_cur = r_mtime;
      default:  w_cur = '0;
    endcase
    w_merged = (w_cur & ~w_mask) | (bus.req_wdata_i & w_mask);
  end

  assign w_acc   = (r_state == ST_IDLE) && bus.req_valid_i;
  assign w_wr_ok = w_acc && bus.req_write_i && (w_code == CODE_OK);
  assign w_tick  = (r_presc == PW'(TICK_DIV - 1));

  // A write to mtime replaces the tick in that cycle; merging uses the pre-tick value
  always_comb begin
    w_mtime_nxt = r_mtime + DATA_W'(w_tick);
    if (w_wr_ok && w_region == RG_MTIME) w_mtime_nxt = w_merged;
    for (int h = 0; h < HART_NUM; h++) begin
      w_cmp_nxt[h] = r_cmp[h];
      if (w_wr_ok && w_region == RG_CMP && h == int'(w_off[5:3])) w_cmp_nxt[h] = w_merged;
      w_msip_nxt[h] = r_msip[h];
      if (w_wr_ok && w_region == RG_MSIP && h / 2 == int'(w_off[4:3])) begin
        w_msip_nxt[h] = (h % 2 == 1) ? w_merged[32] : w_merged[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_code       <= CODE_OK;
      r_presc      <= '0;
      r_mtime      <= '0;
      for (int h = 0; h < HART_NUM; h++) r_cmp[h] <= '1;
      r_msip       <= '0;
      r_mtip       <= '0;
      r_update     <= 1'b0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      r_mtime  <= w_mtime_nxt;
      for (int h = 0; h < HART_NUM; h++) begin
        r_cmp[h]  <= w_cmp_nxt[h];
        r_mtip[h] <= (w_mtime_nxt >= w_cmp_nxt[h]);
      end
      r_msip   <= w_msip_nxt;
      r_update <= w_wr_ok;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_code       <= w_code;
            r_rdata      <= (w_code == CODE_OK && !bus.req_write_i) ? (w_cur & w_mask) : '0;
          end
        end
        default: begin
          if (bus.resp_ready_i) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.req_ready_o  = (r_state == ST_IDLE) && !rst;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_rdata_o = r_rdata;
  assign bus.resp_code_o  = r_code;
  assign mtip_o           = r_mtip;
  assign msip_o           = r_msip;
  assign update_o         = r_update;
endmodule

// File: tb/tb_mem_clint_mh.sv
// Randomized scoreboard bench for mem_clint_mh; mtime is modelled as a closed-form
// function of elapsed clock edges since reset or since the last mtime write.
module tb_mem_clint_mh;
  localparam int          H    = 2;
  localparam int          T    = 4;
  localparam logic [63:0] BASE = 64'h0200_0000;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  code;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [H-1:0] mtip;
  logic [H-1:0] msip;
  logic         upd;

  mem_clint_mh_if #(.ADDR_W(64)) bus ();

  mem_clint_mh #(
    .HART_NUM (H),
    .DATA_W   (64),
    .ADDR_W   (64),
    .BASE_ADDR(BASE),
    .TICK_DIV (T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mtip_o  (mtip),
    .msip_o  (msip),
    .update_o(upd)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        q[$];
  int unsigned e = 0;
  bit          in_rst = 1'b0;
  bit          stall = 1'b1;
  logic [63:0] mv = '0;
  int unsigned mw = 0;
  logic [63:0] cmp_m [H];
  logic [H-1:0] msip_m = '0;
  int unsigned upd_edge = 0;
  bit          upd_vld = 1'b0;

  // e = clock edges taken outside reset; a tick lands on every T-th such edge
  always @(posedge clk) begin
    in_rst <= rst;
    e      <= rst ? 0 : e + 1;
  end

  function automatic logic [63:0] mtime_at(int unsigned n);
    return mv + 64'(n / T) - 64'(mw / T);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, e);
  endtask

  task automatic issue(input bit wr, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wd);
    logic [63:0] off, cur, nv, rd;
    logic [1:0]  code;
    int          rgn, nb, ln, waited;
    int unsigned a;
    exp_t        x;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_size_i  = size;
    bus.req_wdata_i = wd;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.req_ready_o && waited < 200);
    if (!bus.req_ready_o) begin
      n_chk++;
      $display("FAIL req_timeout: req_ready_o still 0 after %0d cycles, expected 1", waited);
      bus.req_valid_i = 1'b0;
      return;
    end
    a   = e + 1;
    off = addr - BASE;
    nb  = 1 << size;
    ln  = int'(addr[2:0]);
    if (off < 64'(4 * H)) rgn = 0;
    else if (off >= 64'h4000 && off < 64'h4000 + 64'(8 * H)) rgn = 1;
    else if (off >= 64'hBFF8 && off < 64'hC000) rgn = 2;
    else rgn = 3;
    if (rgn == 3) code = 2'b11;
    else if ((ln % nb) != 0 || (rgn == 0 && size == 2'd3)) code = 2'b10;
    else code = 2'b00;
    cur = '0;
    case (rgn)
      0: for (int h = 0; h < H; h++) if (h / 2 == int'(off >> 3)) cur[32 * (h % 2)] = msip_m[h];
      1: cur = cmp_m[int'((off - 64'h4000) >> 3)];
      2: cur = mtime_at(e);
      default: cur = '0;
    endcase
    rd = '0;
    nv = cur;
    if (code == 2'b00) begin
      for (int i = ln; i < ln + nb; i++) begin
        if (wr) nv[8*i +: 8] = wd[8*i +: 8];
        else    rd[8*i +: 8] = cur[8*i +: 8];
      end
    end
    x.rdata = rd;
    x.code  = code;
    q.push_back(x);
    @(posedge clk);
    if (wr && code == 2'b00) begin
      upd_edge = a;
      upd_vld  = 1'b1;
      case (rgn)
        0: for (int h = 0; h < H; h++) if (h / 2 == int'(off >> 3)) msip_m[h] = nv[32 * (h % 2)];
        1: cmp_m[int'((off - 64'h4000) >> 3)] = nv;
        default: begin mv = nv; mw = a; end
      endcase
    end
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    repeat (cyc) @(posedge clk);
    mv = '0;
    mw = 0;
    for (int h = 0; h < H; h++) cmp_m[h] = '1;
    msip_m  = '0;
    upd_vld = 1'b0;
    q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && bus.resp_valid_o; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_txn();
    int          sel, sz, ln;
    logic [63:0] ad;
    sel = $urandom_range(0, 5);
    sz  = $urandom_range(0, 3);
    case (sel)
      0: ad = BASE;
      1: ad = BASE + 64'h4000 + 64'(8 * $urandom_range(0, H - 1));
      2: ad = BASE + 64'hBFF8;
      3: ad = BASE + 64'($urandom_range(0, 16'hFFFF));
      4: ad = BASE + 64'h4000 + 64'(8 * H);
      default: ad = BASE - 64'h8;
    endcase
    if (sel != 3) begin
      ln = $urandom_range(0, 7);
      if ($urandom_range(0, 7) != 0) ln = ln & ~((1 << sz) - 1);
      ad[2:0] = 3'(ln);
    end
    issue(1'($urandom_range(0, 1)), ad, 2'(sz), {$urandom, $urandom});
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.resp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2 bus.resp_ready_i = stall ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (in_rst) begin
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'(!rst));
        chk("rst_mtip", 64'(mtip), 64'(0));
        chk("rst_msip", 64'(msip), 64'(0));
        chk("rst_update", 64'(upd), 64'(0));
      end else begin
        for (int h = 0; h < H; h++) chk("mtip", 64'(mtip[h]), 64'(mtime_at(e) >= cmp_m[h]));
        chk("msip", 64'(msip), 64'(msip_m));
        chk("update", 64'(upd), 64'(upd_vld && e == upd_edge));
        if (bus.resp_valid_o) begin
          chk("req_ready_busy", 64'(bus.req_ready_o), 64'(0));
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_resp: resp_valid_o=1 with no outstanding request");
          end else begin
            chk("rdata", bus.resp_rdata_o, q[0].rdata);
            chk("code", 64'(bus.resp_code_o), 64'(q[0].code));
            if (bus.resp_ready_i) q.delete(0);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_size_i  = '0;
    bus.req_wdata_i = '0;
    do_reset(4);
    stall = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue(1'b0, BASE + 64'hBFF8, 2'd3, '0);
    issue(1'b0, BASE + 64'h4000, 2'd3, '0);
    issue(1'b1, BASE + 64'h4008, 2'd3, 64'h20);
    repeat (140) @(posedge clk);
    #1;
    issue(1'b1, BASE + 64'hBFF8, 2'd3, 64'h1000);
    issue(1'b1, BASE + 64'hBFFA, 2'd0, 64'h0000_0000_00AB_0000);
    issue(1'b0, BASE + 64'hBFF8, 2'd3, '0);
    issue(1'b1, BASE + 64'h4,    2'd2, 64'h0000_0001_0000_0000);
    issue(1'b0, BASE + 64'h4,    2'd2, '0);
    issue(1'b0, BASE,            2'd3, '0);
    issue(1'b1, BASE + 64'hBFF9, 2'd1, '1);
    issue(1'b0, BASE + 64'h8000, 2'd3, '0);
    issue(1'b0, BASE + 64'hBFFC, 2'd2, '0);
    wait_idle();
    stall = 1'b1;
    issue(1'b0, BASE + 64'hBFF8, 2'd3, '0);
    repeat (6) @(posedge clk);
    #1 stall = 1'b0;
    issue(1'b1, BASE + 64'h4000, 2'd3, 64'h2);
    issue(1'b1, BASE + 64'hBFF8, 2'd3, '1);
    repeat (20) @(posedge clk);
    #1;
    issue(1'b0, BASE + 64'hBFF8, 2'd3, '0);
    for (int k = 0; k < 300; k++) rand_txn();
    wait_idle();
    stall = 1'b1;
    issue(1'b0, BASE + 64'h4008, 2'd3, '0);
    @(posedge clk);
    #1;
    do_reset(3);
    stall = 1'b0;
    for (int k = 0; k < 100; k++) rand_txn();
    wait_idle();
    repeat (2) @(posedge clk);
    chk("drain", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
